// File: rtl/traffic_seq_pkg.sv
// Shared definitions for the traffic sequencer and its phase timer:
// road indices, light colours, phase codes and phase decode helpers.
package traffic_seq_pkg;

    localparam int NUM_ROADS = 4;

    typedef enum logic [1:0] {
        ROAD_N = 2'd0,
        ROAD_E = 2'd1,
        ROAD_S = 2'd2,
        ROAD_W = 2'd3
    } road_e;

    typedef enum logic [1:0] {
        LIGHT_RED   = 2'b00,
        LIGHT_YEL   = 2'b01,
        LIGHT_GREEN = 2'b10
    } light_e;

    // Phase code for road r and step s is 3*r + s + 1; 0 is all-red.
    typedef enum logic [3:0] {
        PH_ALL_RED = 4'd0,
        PH_N_GREEN = 4'd1,  PH_N_EXT = 4'd2,  PH_N_YEL = 4'd3,
        PH_E_GREEN = 4'd4,  PH_E_EXT = 4'd5,  PH_E_YEL = 4'd6,
        PH_S_GREEN = 4'd7,  PH_S_EXT = 4'd8,  PH_S_YEL = 4'd9,
        PH_W_GREEN = 4'd10, PH_W_EXT = 4'd11, PH_W_YEL = 4'd12
    } phase_e;

    // Position inside one road's service; STEP_NONE covers all-red and illegal codes.
    typedef enum logic [1:0] {
        STEP_GREEN = 2'd0,
        STEP_EXT   = 2'd1,
        STEP_YEL   = 2'd2,
        STEP_NONE  = 2'd3
    } step_e;

    typedef struct packed {
        step_e       step;
        logic [1:0]  road;
    } phase_info_t;

    function automatic logic [3:0] phase_code(input logic [1:0] road, input step_e step);
        return 4'(road) * 4'd3 + 4'(step) + 4'd1;
    endfunction

    function automatic phase_info_t decode_phase(input logic [3:0] code);
        phase_info_t info;
        info.step = STEP_NONE;
        info.road = 2'd0;
        if (code >= 4'd1 && code <= 4'd12) begin
            info.road = 2'((code - 4'd1) / 4'd3);
            info.step = step_e'(2'((code - 4'd1) % 4'd3));
        end
        return info;
    endfunction

    function automatic light_e light_for(input logic [3:0] code, input logic [1:0] road);
        phase_info_t info;
        info = decode_phase(code);
        if (info.step == STEP_NONE || info.road != road) return LIGHT_RED;
        if (info.step == STEP_YEL) return LIGHT_YEL;
        return LIGHT_GREEN;
    endfunction

endpackage

// File: rtl/traffic_seq_ctrl_rr_road_select.sv
// Cyclic demand search: first road after last_road (ascending, wrapping)
// with demand; with no demand at all, the plain rotation last_road+1.
module rr_road_select (
    input  logic [1:0] last_road,
    input  logic [3:0] demand,
    output logic [1:0] next_road
);

    logic       found;
    logic [1:0] cand;

    // Scan offsets 1..4 so last_road itself is considered last.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        next_road = last_road + 2'd1;
        found     = 1'b0;
        cand      = last_road;
        for (int i = 1; i <= 4; i++) begin
            cand = last_road + 2'(i);
            if (!found && demand[cand]) begin
                next_road = cand;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_seq_ctrl.sv
// Four-way traffic phase sequencer: steps through green / optional
// extension / yellow / all-red on timer expiry, serves roads round-robin
// by demand, and gives emergency vehicles priority at the all-red point.
module traffic_seq_ctrl
    import traffic_seq_pkg::*;
#(
    parameter int NUM_ROADS = traffic_seq_pkg::NUM_ROADS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 expired,
    input  logic [NUM_ROADS-1:0] car_present,
    input  logic [NUM_ROADS-1:0] congested,
    input  logic                 emerg_req,
    input  logic [1:0]           emerg_road,
    output logic [3:0]           state,
    output logic [1:0]           light_n,
    output logic [1:0]           light_e,
    output logic [1:0]           light_s,
    output logic [1:0]           light_w,
    output logic                 emerg_ack
);

    // Kept as raw 4-bit code so an illegal value is representable and recoverable.
    logic [3:0]            state_q, state_d;
    logic [1:0]            last_road_q, last_road_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [1:0]            pend_road_q, pend_road_d;
    logic                  ack_q, ack_d;
    logic [3:0][1:0]       light_q, light_d;

    phase_info_t           cur;
    logic [1:0]            rr_road;
    logic                  pend_eff_valid;
    logic [1:0]            pend_eff_road;
    logic                  consume;

    // A request arriving this cycle is treated as already pending.
    assign pend_eff_valid = emerg_req | pend_valid_q;
    assign pend_eff_road  = emerg_req ? emerg_road : pend_road_q;
    assign cur            = decode_phase(state_q);

    rr_road_select u_rr (
        .last_road (last_road_q),
        .demand    (car_present[3:0]),
        .next_road (rr_road)
    );

    // Next phase, rotation history, emergency bookkeeping and next lights.
    always_comb begin
        state_d      = state_q;
        last_road_d  = last_road_q;
        ack_d        = 1'b0;
        consume      = 1'b0;

        if (pend_eff_valid && (cur.step == STEP_GREEN || cur.step == STEP_EXT)
            && pend_eff_road == cur.road) begin
            ack_d   = 1'b1;
            consume = 1'b1;
        end

        if (expired) begin
            case (cur.step)
                STEP_GREEN: begin
                    if (congested[cur.road] && !(pend_eff_valid && pend_eff_road != cur.road))
                        state_d = phase_code(cur.road, STEP_EXT);
                    else
                        state_d = phase_code(cur.road, STEP_YEL);
                end
                STEP_EXT: state_d = phase_code(cur.road, STEP_YEL);
                STEP_YEL: begin
                    state_d     = PH_ALL_RED;
                    last_road_d = cur.road;
                end
                default: begin
                    if (state_q != PH_ALL_RED) begin
                        state_d = PH_ALL_RED;
                    end else if (pend_eff_valid) begin
                        state_d = phase_code(pend_eff_road, STEP_GREEN);
                        ack_d   = 1'b1;
                        consume = 1'b1;
                    end else begin
                        state_d = phase_code(rr_road, STEP_GREEN);
                    end
                end
            endcase
        end

        pend_valid_d = pend_valid_q;
        pend_road_d  = pend_road_q;
        if (consume) begin
            pend_valid_d = 1'b0;
        end else if (emerg_req) begin
            pend_valid_d = 1'b1;
            pend_road_d  = emerg_road;
        end

        // Lights are decoded from the next state so they update on the same edge.
        for (int r = 0; r < 4; r++)
            light_d[r] = light_for(state_d, 2'(r));
    end

    // State, history, emergency and light registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PH_ALL_RED;
            last_road_q  <= ROAD_W;
            pend_valid_q <= 1'b0;
            pend_road_q  <= 2'd0;
            ack_q        <= 1'b0;
            light_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q      <= state_d;
            last_road_q  <= last_road_d;
            pend_valid_q <= pend_valid_d;
            pend_road_q  <= pend_road_d;
            ack_q        <= ack_d;
            light_q      <= light_d;
        end
    end

    assign state     = state_q;
    assign emerg_ack = ack_q;
    assign light_n   = light_q[ROAD_N];
    assign light_e   = light_q[ROAD_E];
    assign light_s   = light_q[ROAD_S];
    assign light_w   = light_q[ROAD_W];

endmodule

// File: doc/traffic_seq_ctrl.md
TRAFFIC_SEQ_CTRL -- requirements
Module: traffic_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROADS, default 4, fixed number of approaches (N=0, E=1, S=2, W=3); other values unsupported.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic rises on posedge clk.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port expired, input, 1, one-cycle pulse from the phase timer ending the current phase.
REQ-005 SHALL have port car_present, input, 4, per-road demand (bit i = road i).
REQ-006 SHALL have port congested, input, 4, per-road congestion flag.
REQ-007 SHALL have port emerg_req, input, 1, emergency-vehicle request, level.
REQ-008 SHALL have port emerg_road, input, 2, road requested by the emergency vehicle.
REQ-009 SHALL have port state, output, 4, current phase code driven to the phase timer.
REQ-010 SHALL have port light_n, light_e, light_s and light_w, output, 2 each, light colour: 00 red, 01 yellow, 10 green.
REQ-011 SHALL have port emerg_ack, output, 1, one-cycle pulse when the emergency road is granted green.

Function
REQ-012 SHALL encode phases as: 0 ALL_RED; per road r (0..3): GREEN = 3r+1, EXT = 3r+2, YEL = 3r+3; codes 13-15 are illegal.
REQ-013 SHALL change state only on a cycle with expired=1 and hold state otherwise.
REQ-014 SHALL, on expiry in GREEN(r), go to EXT(r) if congested[r]=1 and no emergency is pending for another road, else to YEL(r).
REQ-015 SHALL, on expiry in EXT(r), go to YEL(r); extension is granted at most once per service.
REQ-016 SHALL, on expiry in YEL(r), go to ALL_RED and record r as last_road.
REQ-017 SHALL, on expiry in ALL_RED with no pending emergency, grant GREEN of the first road after last_road (cyclic, ascending) with car_present set.
REQ-018 SHALL, on expiry in ALL_RED with car_present=0000, grant GREEN(last_road+1 mod 4) as the default rotation.
REQ-019 SHALL latch emerg_road into a pending register on any cycle with emerg_req=1; a later request overwrites it.
REQ-020 SHALL give a pending emergency priority at ALL_RED expiry over round-robin, grant GREEN(emerg_road), clear the pending register, and pulse emerg_ack in the same cycle the state becomes that GREEN.
REQ-021 SHALL, if the pending emergency road equals the road currently in GREEN/EXT, clear the pending register immediately and pulse emerg_ack without changing state.
REQ-022 SHALL sample car_present and congested only on the expiry cycle; no other inputs affect transitions.
REQ-023 SHALL register the light outputs so they change on the same edge as state: road r is green in GREEN/EXT(r), yellow in YEL(r), and red otherwise; in ALL_RED all roads are red.
REQ-024 SHALL go to ALL_RED on the next expiry if an illegal state code is ever reached.
REQ-025 SHALL have at most one road non-red at any time.

Reset
REQ-026 SHALL, while rst_n=0, force state=ALL_RED, all lights=00, emerg_ack=0, pending emergency cleared, and last_road=3 so that N is served first.
REQ-027 SHALL take effect asynchronously on assertion and release synchronously, with the first transition on the first expiry after release.
REQ-028 SHALL, when reset is asserted mid-phase, discard any extension, pending emergency and rotation history.

Structure
REQ-029 SHALL place the phase codes, light colour codes, road indices and NUM_ROADS in a shared package also used by the phase timer.
REQ-030 SHALL implement the cyclic demand search (last_road, car_present -> next road) as the sub-module rr_road_select (combinational, 4-way).

Verification
REQ-031 SHALL cover: reset release, car_present=1111, congested=0, expired pulsed each phase -> state 0,1,3,0,4,6,0,7,9,0,10,12,0 with N,E,S,W each green once.
REQ-032 SHALL cover: in state 4 (E_GREEN), congested=0010 at expiry -> state 5, then 6; congested still 0010 at EXT expiry -> no second extension.
REQ-033 SHALL cover: last_road=0 with car_present=1000 at ALL_RED expiry -> state 10 (W_GREEN), skipping E and S.
REQ-034 SHALL cover: in state 1 (N_GREEN) with congested[0]=1, emerg_req=1 and emerg_road=2 -> state 3 then 0 then 7, with emerg_ack=1 on the cycle state becomes 7.
REQ-035 SHALL cover: emerg_road=0 asserted while in state 2 (N_EXT) -> emerg_ack pulses the next cycle and state stays 2.
REQ-036 SHALL cover: rst_n dropped while in state 8 with a pending emergency -> state=0, all lights 00 and pending cleared immediately, then N served first after release.
